// File: rtl/partial_knn_mem_pkg.sv
// partial_knn_mem_pkg: shared write modes, FSM states and helpers for the partialKnn URAM buffers
package partial_knn_mem_pkg;
  localparam int WM_READ_FIRST  = 0;
  localparam int WM_WRITE_FIRST = 1;
  typedef enum logic {ST_CLEAR, ST_READY} mem_state_t;
  function automatic int clog2(input longint unsigned v);
    int r;
    r = 0;
    for (longint unsigned x = 1; x < v; x = x << 1) r++;
    return r;
  endfunction
endpackage

// File: rtl/partial_knn_rd_pipe.sv
// partial_knn_rd_pipe: read delay line carrying {valid, data}; data advances only with valid so it holds
module partial_knn_rd_pipe #(
  parameter int DW     = 256,
  parameter int STAGES = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  output logic [DW-1:0] out_data
);
  if (STAGES == 0) begin : g_bypass
    assign out_valid = in_valid;
    assign out_data  = in_data;
  end else begin : g_pipe
    logic [STAGES-1:0] v_q;
    logic [STAGES:0]   v_n;
    logic [DW-1:0]     d_q [STAGES];
    assign v_n = {v_q, in_valid};
    always_ff @(posedge clk or posedge reset)
      if (reset) v_q <= '0;
      else v_q <= v_n[STAGES-1:0];
    always_ff @(posedge clk) begin
      if (in_valid) d_q[0] <= in_data;
      for (int k = 1; k < STAGES; k++)
        if (v_q[k-1]) d_q[k] <= d_q[k-1];
    end
    assign out_valid = v_q[STAGES-1];
    assign out_data  = d_q[STAGES-1];
  end
endmodule

// File: rtl/partial_knn_uram_sdp_mem.sv
// partial_knn_uram_sdp_mem: simple-dual-port URAM word buffer with byte enables, read pipeline and post-reset clear
module partial_knn_uram_sdp_mem
  import partial_knn_mem_pkg::*;
#(
  parameter int DATA_WIDTH   = 256,
  parameter int DEPTH        = 2048,
  parameter int ADDR_WIDTH   = 11,
  parameter int READ_LATENCY = 2,
  parameter int WRITE_MODE   = WM_READ_FIRST,
  parameter int INIT_CLEAR   = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wr_en,
  input  logic [ADDR_WIDTH-1:0]     wr_addr,
  input  logic [DATA_WIDTH/8-1:0]   wr_be,
  input  logic [DATA_WIDTH-1:0]     wr_data,
  input  logic                      rd_en,
  input  logic [ADDR_WIDTH-1:0]     rd_addr,
  output logic                      rd_valid,
  output logic [DATA_WIDTH-1:0]     rd_data,
  output logic                      init_busy,
  output logic                      oob_err
);
  localparam int BW = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0]   LIMIT = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST  = ADDR_WIDTH'(DEPTH - 1);
  if (DATA_WIDTH % 8 != 0) begin : g_bad_width
    $error("DATA_WIDTH must be a multiple of 8");
  end
  if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
    $error("READ_LATENCY must be in 1..4");
  end
  if (clog2(DEPTH) > ADDR_WIDTH) begin : g_bad_addr
    $error("ADDR_WIDTH too small for DEPTH");
  end
  (* ram_style = "ultra" *) logic [DATA_WIDTH-1:0] mem [DEPTH];
  mem_state_t state, state_n;
  logic [ADDR_WIDTH-1:0] clr_addr, mem_addr;
  logic [BW-1:0] mem_be, fwd_be;
  logic [DATA_WIDTH-1:0] mem_data, rd_raw, fwd_data, s1_data, p_data;
  logic wr_in, rd_in, wr_go, rd_go, s1_valid, s1_oob, s1_fwd, p_valid, primed;
  assign init_busy = state == ST_CLEAR;
  assign wr_in     = {1'b0, wr_addr} < LIMIT;
  assign rd_in     = {1'b0, rd_addr} < LIMIT;
  assign wr_go     = !init_busy && wr_en && wr_in;
  assign rd_go     = !init_busy && rd_en;
  // the clear sweep borrows the single write port until the last word is zeroed
  assign mem_addr  = init_busy ? clr_addr : wr_addr;
  assign mem_be    = init_busy ? '1 : wr_go ? wr_be : '0;
  assign mem_data  = init_busy ? '0 : wr_data;
  always_comb state_n = (init_busy && clr_addr == LAST) ? ST_READY : state;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state    <= INIT_CLEAR != 0 ? ST_CLEAR : ST_READY;
      clr_addr <= '0;
    end else begin
      state <= state_n;
      if (init_busy) clr_addr <= clr_addr + 1'b1;
    end
  always_ff @(posedge clk) begin
    for (int b = 0; b < BW; b++)
      if (mem_be[b]) mem[mem_addr][8*b +: 8] <= mem_data[8*b +: 8];
    if (rd_go) begin
      rd_raw   <= mem[rd_addr];
      fwd_data <= wr_data;
      fwd_be   <= wr_be;
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      s1_valid <= 1'b0;
      s1_oob   <= 1'b0;
      s1_fwd   <= 1'b0;
      primed   <= 1'b0;
      oob_err  <= 1'b0;
    end else begin
      s1_valid <= rd_go;
      if (rd_go) begin
        s1_oob <= !rd_in;
        s1_fwd <= WRITE_MODE == WM_WRITE_FIRST && wr_go && wr_addr == rd_addr;
      end
      if (p_valid) primed <= 1'b1;
      if (!init_busy && ((wr_en && !wr_in) || (rd_en && !rd_in))) oob_err <= 1'b1;
    end
  // write-first collisions overlay the registered write bytes on the pre-write word
  always_comb begin
    s1_data = rd_raw;
    for (int b = 0; b < BW; b++)
      if (s1_fwd && fwd_be[b]) s1_data[8*b +: 8] = fwd_data[8*b +: 8];
    if (s1_oob) s1_data = '0;
  end
  partial_knn_rd_pipe #(.DW(DATA_WIDTH), .STAGES(READ_LATENCY - 1)) u_rd_pipe (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (s1_valid),
    .in_data   (s1_data),
    .out_valid (p_valid),
    .out_data  (p_data)
  );
  assign rd_valid = p_valid;
  assign rd_data  = (primed || p_valid) ? p_data : '0;
endmodule

// File: tb/tb_partial_knn_uram_sdp_mem.sv
// tb_partial_knn_uram_sdp_mem: three configurations driven in lockstep against a per-instance reference model
module tb_partial_knn_uram_sdp_mem;
  localparam int DW = 256;
  localparam int BW = 32;
  localparam int AW = 11;
  localparam int DEP [3] = '{2000, 2048, 2000};
  localparam int RL  [3] = '{2, 1, 4};
  localparam int WM  [3] = '{0, 1, 1};
  localparam logic [DW-1:0] Z  = '0;
  localparam logic [DW-1:0] FF = {DW{1'b1}};
  localparam logic [DW-1:0] AA = {32{8'hAA}};
  localparam logic [DW-1:0] H5 = {32{8'h55}};
  localparam logic [DW-1:0] H1 = {32{8'h11}};
  localparam logic [DW-1:0] CC = {32{8'hCC}};
  localparam logic [DW-1:0] H7 = {32{8'h77}};
  localparam logic [DW-1:0] LO0 = {{28{8'hFF}}, {4{8'h00}}};
  localparam logic [DW-1:0] MRG = {{24{8'h55}}, {8{8'h11}}};
  localparam logic [BW-1:0] ALL = '1;

  typedef struct {
    logic          we;
    logic [AW-1:0] wa;
    logic [BW-1:0] be;
    logic [DW-1:0] wd;
    logic          re;
    logic [AW-1:0] ra;
    logic [DW-1:0] e0, e1, e2;
  } vec_t;

  logic clk, reset, wr_en, rd_en;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [BW-1:0] wr_be;
  logic [DW-1:0] wr_data;
  logic rv [3];
  logic ib [3];
  logic oe [3];
  logic [DW-1:0] rdd [3];

  logic [DW-1:0] mem_m [3][2048];
  int rem [3];
  bit oob_m [3];
  bit pv [3][8];
  logic [DW-1:0] pd [3][8];
  logic [DW-1:0] last [3];
  int cyc, checks, errors;
  bit tbl_mode;
  vec_t cur;
  vec_t vec [17];

  partial_knn_uram_sdp_mem #(.DEPTH(2000), .READ_LATENCY(2), .WRITE_MODE(0), .INIT_CLEAR(1)) u0 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rv[0]), .rd_data(rdd[0]), .init_busy(ib[0]), .oob_err(oe[0]));
  partial_knn_uram_sdp_mem #(.DEPTH(2048), .READ_LATENCY(1), .WRITE_MODE(1), .INIT_CLEAR(1)) u1 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rv[1]), .rd_data(rdd[1]), .init_busy(ib[1]), .oob_err(oe[1]));
  partial_knn_uram_sdp_mem #(.DEPTH(2000), .READ_LATENCY(4), .WRITE_MODE(1), .INIT_CLEAR(1)) u2 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rv[2]), .rd_data(rdd[2]), .init_busy(ib[2]), .oob_err(oe[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] o, input logic [DW-1:0] n, input logic [BW-1:0] be);
    for (int b = 0; b < BW; b++) if (be[b]) o[8*b +: 8] = n[8*b +: 8];
    return o;
  endfunction

  function automatic logic [DW-1:0] rnd();
    logic [DW-1:0] r;
    for (int k = 0; k < DW / 32; k++) r[32*k +: 32] = $urandom;
    return r;
  endfunction

  function automatic vec_t mk(input logic we, input int wa, input logic [BW-1:0] be, input logic [DW-1:0] wd,
                              input logic re, input int ra, input logic [DW-1:0] e0, input logic [DW-1:0] e1,
                              input logic [DW-1:0] e2);
    vec_t v;
    v.we = we; v.wa = AW'(wa); v.be = be; v.wd = wd;
    v.re = re; v.ra = AW'(ra); v.e0 = e0; v.e1 = e1; v.e2 = e2;
    return v;
  endfunction

  task automatic chk(input string name, input int i, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %h want %h", name, i, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [BW-1:0] be, input logic [DW-1:0] wd,
                       input logic re, input logic [AW-1:0] ra);
    wr_en = we; wr_addr = wa; wr_be = be; wr_data = wd; rd_en = re; rd_addr = ra;
  endtask

  task automatic rand_op();
    rd_addr = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(1990, 2047)) : AW'($urandom_range(0, 63));
    wr_addr = ($urandom_range(0, 3) == 0) ? rd_addr : AW'($urandom_range(0, 63));
    wr_en   = $urandom_range(0, 2) != 0;
    rd_en   = $urandom_range(0, 2) != 0;
    wr_be   = ($urandom_range(0, 3) == 0) ? ALL : BW'($urandom);
    wr_data = rnd();
  endtask

  task automatic model_edge();
    logic [DW-1:0] v;
    cyc++;
    for (int i = 0; i < 3; i++) begin
      if (rem[i] > 0) rem[i]--;
      else begin
        if (rd_en) begin
          v = (int'(rd_addr) < DEP[i]) ? mem_m[i][rd_addr] : Z;
          if (WM[i] == 1 && wr_en && wr_addr == rd_addr && int'(rd_addr) < DEP[i]) v = merge(v, wr_data, wr_be);
          if (tbl_mode) v = (i == 0) ? cur.e0 : (i == 1) ? cur.e1 : cur.e2;
          pv[i][(cyc + RL[i] - 1) % 8] = 1'b1;
          pd[i][(cyc + RL[i] - 1) % 8] = v;
        end
        if (wr_en && int'(wr_addr) < DEP[i]) mem_m[i][wr_addr] = merge(mem_m[i][wr_addr], wr_data, wr_be);
        if ((rd_en && int'(rd_addr) >= DEP[i]) || (wr_en && int'(wr_addr) >= DEP[i])) oob_m[i] = 1'b1;
      end
    end
  endtask

  task automatic check_all();
    int s;
    s = cyc % 8;
    for (int i = 0; i < 3; i++) begin
      if (pv[i][s]) last[i] = pd[i][s];
      chk("rd_valid", i, DW'(rv[i]), DW'(pv[i][s]));
      chk("rd_data", i, rdd[i], last[i]);
      chk("init_busy", i, DW'(ib[i]), DW'(rem[i] > 0));
      chk("oob_err", i, DW'(oe[i]), DW'(oob_m[i]));
      pv[i][s] = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rem[i] = DEP[i];
      oob_m[i] = 1'b0;
      last[i] = Z;
      for (int s = 0; s < 8; s++) pv[i][s] = 1'b0;
      for (int a = 0; a < 2048; a++) mem_m[i][a] = Z;
    end
    #1;
    check_all();
    @(posedge clk);
    #1;
    check_all();
    reset = 1'b0;
  endtask

  initial begin
    int cnt [3];
    int first [3];
    checks = 0; errors = 0; cyc = 0; tbl_mode = 1'b0;
    vec[0]  = mk(1, 5, ALL, FF, 0, 0, Z, Z, Z);
    vec[1]  = mk(1, 5, 32'h0000_000F, Z, 0, 0, Z, Z, Z);
    vec[2]  = mk(0, 0, '0, Z, 1, 5, LO0, LO0, LO0);
    vec[3]  = mk(1, 7, ALL, AA, 0, 0, Z, Z, Z);
    vec[4]  = mk(1, 7, ALL, H5, 1, 7, AA, H5, H5);
    vec[5]  = mk(0, 0, '0, Z, 1, 7, H5, H5, H5);
    vec[6]  = mk(1, 7, 32'h0000_00FF, H1, 1, 7, H5, MRG, MRG);
    vec[7]  = mk(0, 0, '0, Z, 1, 7, MRG, MRG, MRG);
    vec[8]  = mk(1, 7, ALL, CC, 0, 0, Z, Z, Z);
    vec[9]  = mk(1, 2040, ALL, H7, 0, 0, Z, Z, Z);
    vec[10] = mk(0, 0, '0, Z, 1, 2040, Z, H7, Z);
    vec[11] = mk(0, 0, '0, Z, 1, 40, Z, Z, Z);
    vec[12] = mk(1, 9, '0, FF, 1, 9, Z, Z, Z);
    vec[13] = mk(0, 0, '0, Z, 1, 0, Z, Z, Z);
    vec[14] = mk(0, 0, '0, Z, 1, 1000, Z, Z, Z);
    vec[15] = mk(0, 0, '0, Z, 1, 2047, Z, Z, Z);
    vec[16] = mk(0, 0, '0, Z, 1, 7, CC, CC, CC);
    drive(0, '0, '0, Z, 0, '0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    do_reset();
    repeat (2048) tick();
    tbl_mode = 1'b1;
    for (int n = 0; n < 17; n++) begin
      cur = vec[n];
      drive(cur.we, cur.wa, cur.be, cur.wd, cur.re, cur.ra);
      tick();
    end
    tbl_mode = 1'b0;
    drive(0, '0, '0, Z, 0, '0);
    repeat (6) tick();
    chk("oob_sticky", 0, DW'(oe[0]), DW'(1'b1));
    chk("oob_sticky", 1, DW'(oe[1]), DW'(1'b0));
    chk("oob_sticky", 2, DW'(oe[2]), DW'(1'b1));
    for (int k = 0; k < 16; k++) begin
      drive(1, AW'(k), ALL, DW'(k), 0, '0);
      tick();
    end
    for (int i = 0; i < 3; i++) begin cnt[i] = 0; first[i] = -1; end
    for (int j = 0; j < 22; j++) begin
      if (j < 16) drive(0, '0, '0, Z, 1, AW'(j));
      else drive(0, '0, '0, Z, 0, '0);
      tick();
      for (int i = 0; i < 3; i++)
        if (rv[i]) begin
          if (first[i] < 0) first[i] = j;
          cnt[i]++;
        end
    end
    for (int i = 0; i < 3; i++) begin
      chk("burst_count", i, DW'(cnt[i]), DW'(16));
      chk("burst_first", i, DW'(first[i]), DW'(RL[i] - 1));
    end
    for (int n = 0; n < 1500; n++) begin
      rand_op();
      tick();
    end
    for (int n = 0; n < 3; n++) begin
      drive(0, '0, '0, Z, 1, AW'(n + 1));
      tick();
    end
    do_reset();
    for (int n = 0; n < 100; n++) begin
      rand_op();
      tick();
    end
    do_reset();
    for (int n = 0; n < 2048; n++) begin
      rand_op();
      tick();
    end
    for (int n = 0; n < 200; n++) begin
      rand_op();
      tick();
    end
    drive(0, '0, '0, Z, 0, '0);
    repeat (6) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
